clkgen_ddr_div: RTL and testbench

//  Multi-channel divided-clock generator in the FSBCLK domain. Per channel, produces D0/D1 bit pairs
//  for a downstream ODDR2 forwarder (D0 on C0 = FSBCLK rise, D1 on C1 = falling half).

---
 rtl/clkgen_pkg.sv | 15 +
 rtl/clkgen_div_chan.sv | 59 +++++
 rtl/clkgen_ddr_div.sv | 48 ++++
 tb/tb_clkgen_ddr_div.sv | 119 +++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared types and decode helpers for the divided-clock generator (gating via CLKGEN_GATE_EN)
package clkgen_pkg;
  localparam int DW = 4;
  typedef logic [DW-1:0] div_t;
  typedef enum logic [1:0] {RUN, DRAIN, HOLD} gate_t;
  function automatic logic [1:0] ddr_decode(div_t cnt, div_t div, logic inv);
    return {({cnt, 1'b0} < {1'b0, div}) ^ inv, ({cnt, 1'b1} < {1'b0, div}) ^ inv};
  endfunction
  function automatic logic tc_decode(div_t cnt, div_t div);
    return div != '0 && cnt == div - div_t'(1);
  endfunction
  function automatic div_t ph_clamp(div_t ph, div_t div);
    return ph >= div ? '0 : ph;
  endfunction
endpackage

// File: rtl/clkgen_div_chan.sv
// clkgen_div_chan: one divided-clock channel with counter, pending ratio and RUN/DRAIN/HOLD gate FSM
module clkgen_div_chan
  import clkgen_pkg::*;
#(
  parameter div_t DIV_RST = div_t'(2),
  parameter logic INV     = 1'b0,
  parameter div_t PH      = '0
) (
  input  logic FSBCLK,
  input  logic RST,
  input  logic sync,
  input  logic div_ld,
  input  div_t div_in,
  input  logic en,
  output logic d0,
  output logic d1,
  output logic tc,
  output logic pend
);
  localparam div_t PH_RST = ph_clamp(PH, DIV_RST);
  gate_t state, state_n;
  div_t cnt, div, pend_div, cnt_n, div_n, pend_div_n;
  logic wrap, apply, pend_n, hold_n;
  assign wrap = div == '0 || cnt == div - div_t'(1);
  // gate state register
  always_ff @(posedge FSBCLK)
    state <= RST ? RUN : state_n;
  // gate next state: a dropped enable lets the current period finish before holding
  always_comb
    state_n = en ? RUN : (state == HOLD || wrap) ? HOLD : DRAIN;
  // gate output: channel parked at cnt=0 with outputs forced inactive
  always_comb
    hold_n = state_n == HOLD;
  // next counter, ratio and pending state; SYNC beats apply beats count
  always_comb begin
    apply      = pend && (sync || wrap || state == HOLD);
    div_n      = apply ? pend_div : div;
    cnt_n      = hold_n ? '0 : sync ? ph_clamp(PH, div_n) : (apply || wrap || state == HOLD) ? '0 : cnt + div_t'(1);
    pend_n     = div_ld || (pend && !apply);
    pend_div_n = div_ld ? div_in : pend_div;
  end
  // state and outputs registered from the next-state decode so outputs match the held count
  always_ff @(posedge FSBCLK)
    if (RST) begin
      cnt      <= PH_RST;
      div      <= DIV_RST;
      pend_div <= DIV_RST;
      pend     <= 1'b0;
      {d0, d1} <= ddr_decode(PH_RST, DIV_RST, INV);
      tc       <= tc_decode(PH_RST, DIV_RST);
    end else begin
      cnt      <= cnt_n;
      div      <= div_n;
      pend_div <= pend_div_n;
      pend     <= pend_n;
      {d0, d1} <= hold_n ? {INV, INV} : ddr_decode(cnt_n, div_n, INV);
      tc       <= !hold_n && tc_decode(cnt_n, div_n);
    end
endmodule

// File: rtl/clkgen_ddr_div.sv
// clkgen_ddr_div: multi-channel FSBCLK/DIV generator producing ODDR2 D0/D1 pairs (EN port with CLKGEN_GATE_EN)
module clkgen_ddr_div
  import clkgen_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               DW      = clkgen_pkg::DW,
  parameter logic [NCH*DW-1:0] DIV_RST = {NCH{4'd2}},
  parameter logic [NCH-1:0]    INV     = {NCH{1'b0}},
  parameter logic [NCH*DW-1:0] PH      = {NCH{4'd0}}
) (
  input  logic              FSBCLK,
  input  logic              RST,
  input  logic              SYNC,
  input  logic [NCH-1:0]    DIV_LD,
  input  logic [NCH*DW-1:0] DIV_IN,
`ifdef CLKGEN_GATE_EN
  input  logic [NCH-1:0]    EN,
`endif
  output logic [NCH-1:0]    D0,
  output logic [NCH-1:0]    D1,
  output logic [NCH-1:0]    TC,
  output logic [NCH-1:0]    PEND
);
  logic [NCH-1:0] en;
`ifdef CLKGEN_GATE_EN
  assign en = EN;
`else
  assign en = '1;
`endif
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clkgen_div_chan #(
      .DIV_RST(DIV_RST[i*DW +: DW]),
      .INV    (INV[i]),
      .PH     (PH[i*DW +: DW])
    ) u_chan (
      .FSBCLK(FSBCLK),
      .RST   (RST),
      .sync  (SYNC),
      .div_ld(DIV_LD[i]),
      .div_in(DIV_IN[i*DW +: DW]),
      .en    (en[i]),
      .d0    (D0[i]),
      .d1    (D1[i]),
      .tc    (TC[i]),
      .pend  (PEND[i])
    );
  end
endmodule

// File: tb/tb_clkgen_ddr_div.sv
// tb_clkgen_ddr_div: directed scoreboard bench for clkgen_ddr_div (gating steps with CLKGEN_GATE_EN)
module tb_clkgen_ddr_div;
  logic FSBCLK = 1'b0;
  logic RST = 1'b1, SYNC = 1'b0;
  logic [3:0] DIV_LD = '0;
  logic [15:0] DIV_IN = '0;
  logic [3:0] en = '1;
  logic [3:0] D0, D1, TC, PEND;
  typedef struct {
    string nm;
    logic [3:0] m, d0, d1, tc, pd;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;

  always #5 FSBCLK = ~FSBCLK;

  clkgen_ddr_div #(.NCH(4), .DW(4), .INV(4'b0010), .PH(16'h0200)) dut (
    .FSBCLK(FSBCLK),
    .RST   (RST),
    .SYNC  (SYNC),
    .DIV_LD(DIV_LD),
    .DIV_IN(DIV_IN),
`ifdef CLKGEN_GATE_EN
    .EN    (en),
`endif
    .D0    (D0),
    .D1    (D1),
    .TC    (TC),
    .PEND  (PEND)
  );

  task automatic chk(input string nm, input string f, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s.%s got=%b want=%b", nm, f, got, want);
    end
  endtask

  always @(negedge FSBCLK)
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, "D0", D0 & e.m, e.d0 & e.m);
      chk(e.nm, "D1", D1 & e.m, e.d1 & e.m);
      chk(e.nm, "TC", TC & e.m, e.tc & e.m);
      chk(e.nm, "PEND", PEND & e.m, e.pd & e.m);
    end

  task automatic step(input string nm, input logic r, input logic s, input logic [3:0] ld,
                      input logic [15:0] din, input logic [3:0] e, input logic [3:0] m,
                      input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] tc, input logic [3:0] pd);
    RST = r;
    SYNC = s;
    DIV_LD = ld;
    DIV_IN = din;
    en = e;
    @(posedge FSBCLK);
    sb.push_back('{nm, m, d0, d1, tc, pd});
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step("rst0", 1, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1101, 4'b1101, 4'b0000, 4'b0000);
    step("rst1", 1, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1101, 4'b1101, 4'b0000, 4'b0000);
    step("div2_a", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0010, 4'b0010, 4'b1111, 4'b0000);
    step("ld3_cap", 0, 0, 4'h1, 16'h0003, 4'hF, 4'hF, 4'b1101, 4'b1101, 4'b0000, 4'b0001);
    step("ld3_pend", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0010, 4'b0010, 4'b1111, 4'b0001);
    step("div3_c0", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1101, 4'b1101, 4'b0000, 4'b0000);
    step("div3_c1", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0011, 4'b0010, 4'b1110, 4'b0000);
    step("div3_c2", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1100, 4'b1100, 4'b0001, 4'b0000);
    step("div3_c0b", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0011, 4'b0011, 4'b1110, 4'b0000);
    step("ld1_cap", 0, 0, 4'h2, 16'h0010, 4'hF, 4'hF, 4'b1101, 4'b1100, 4'b0000, 4'b0010);
    step("ld1_pend", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0010, 4'b0010, 4'b1111, 4'b0010);
    step("div1_inv_a", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1101, 4'b1111, 4'b0010, 4'b0000);
    step("div1_inv_b", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0001, 4'b0010, 4'b1110, 4'b0000);
    step("ld0_cap", 0, 0, 4'h2, 16'h0000, 4'hF, 4'hF, 4'b1100, 4'b1110, 4'b0011, 4'b0010);
    step("div0_stop", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0011, 4'b0011, 4'b1100, 4'b0000);
    step("div0_held", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1111, 4'b1110, 4'b0000, 4'b0000);
    step("ld4_cap", 0, 0, 4'h5, 16'h0404, 4'hF, 4'hF, 4'b0010, 4'b0010, 4'b1101, 4'b0101);
    step("sync", 0, 1, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1011, 4'b1011, 4'b0000, 4'b0000);
    step("sync_c1", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0011, 4'b0011, 4'b1100, 4'b0000);
    step("sync_c2", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1110, 4'b1110, 4'b0000, 4'b0000);
    step("sync_c3", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0110, 4'b0110, 4'b1001, 4'b0000);
    step("ld5_cap", 0, 0, 4'h8, 16'h5000, 4'hF, 4'hF, 4'b1011, 4'b1011, 4'b0000, 4'b1000);
    step("rst_mid", 1, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b1101, 4'b1101, 4'b0000, 4'b0000);
    step("rst_after", 0, 0, 4'h0, 16'h0000, 4'hF, 4'hF, 4'b0010, 4'b0010, 4'b1111, 4'b0000);
    step("ow_cap", 0, 0, 4'h1, 16'h0003, 4'hF, 4'h1, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    step("ow_over", 0, 0, 4'h1, 16'h0001, 4'hF, 4'h1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    step("ld_at_apply", 0, 0, 4'h1, 16'h0003, 4'hF, 4'h1, 4'b0001, 4'b0000, 4'b0001, 4'b0001);
    step("apply_again", 0, 0, 4'h0, 16'h0000, 4'hF, 4'h1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step("div3_run", 0, 0, 4'h0, 16'h0000, 4'hF, 4'h1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
`ifdef CLKGEN_GATE_EN
    step("g_ld4", 0, 0, 4'h1, 16'h0004, 4'hF, 4'h1, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
    step("g_c0", 0, 0, 4'h0, 16'h0000, 4'hF, 4'h1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step("g_c1", 0, 0, 4'h0, 16'h0000, 4'hF, 4'h1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step("g_drain2", 0, 0, 4'h0, 16'h0000, 4'hE, 4'h1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("g_drain3", 0, 0, 4'h0, 16'h0000, 4'hE, 4'h1, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    step("g_hold_a", 0, 0, 4'h0, 16'h0000, 4'hE, 4'h1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("g_hold_b", 0, 0, 4'h0, 16'h0000, 4'hE, 4'h1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("g_restart", 0, 0, 4'h0, 16'h0000, 4'hF, 4'h1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step("g_run1", 0, 0, 4'h0, 16'h0000, 4'hF, 4'h1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
`endif
    repeat (2) @(negedge FSBCLK);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
